// File: rtl/mem_wb_stage.sv
// MEM/WB stage: 2-entry in-order skid buffer between the memory stage and the register file.
// Write data is muxed at accept time; the head entry drives the register-file write port.
`ifndef WORD
`define WORD 64
`endif

module mem_wb_stage #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  im_clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`WORD-1:0]      read_data,
  input  logic [`WORD-1:0]      alu_result,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  mem_to_reg,
  input  logic                  reg_write,
  input  logic                  flush,
  input  logic                  wb_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [`WORD-1:0]      rf_wdata,
  output logic [15:0]           retire_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [`WORD-1:0]      wdata;
    logic [REG_ADDR_W-1:0] waddr;
    logic                  reg_write;
  } entry_t;

  localparam logic [REG_ADDR_W-1:0] XzrAddr = {REG_ADDR_W{1'b1}};

  state_e      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [15:0] count_q, count_d;

  entry_t new_entry;
  logic   accept;
  logic   retire;

  always_comb begin
    new_entry.wdata     = mem_to_reg ? read_data : alu_result;
    new_entry.waddr     = write_reg;
    new_entry.reg_write = reg_write;
  end

  assign in_ready = rst_n && (state_q != StTwo);
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = rst_n && (state_q != StEmpty) && !wb_stall && !flush;

  assign rf_we        = head_q.reg_write && retire && (head_q.waddr != XzrAddr);
  assign rf_waddr     = head_q.waddr;
  assign rf_wdata     = head_q.wdata;
  assign retire_count = count_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = retire ? count_q + 16'd1 : count_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = new_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          // Accept with simultaneous retire replaces the head in place.
          if (accept && retire) begin
            head_d = new_entry;
          end else if (accept) begin
            tail_d  = new_entry;
            state_d = StTwo;
          end else if (retire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (retire) begin
            head_d  = tail_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge im_clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load path, XZR, backpressure, flush, mid-op reset, counter wrap.
`ifndef WORD
`define WORD 64
`endif

module tb_mem_wb_stage;

  logic              im_clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [`WORD-1:0]  read_data;
  logic [`WORD-1:0]  alu_result;
  logic [4:0]        write_reg;
  logic              mem_to_reg;
  logic              reg_write;
  logic              flush;
  logic              wb_stall;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [`WORD-1:0]  rf_wdata;
  logic [15:0]       retire_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 im_clk = ~im_clk;

  mem_wb_stage #(.REG_ADDR_W(5)) dut (
    .im_clk       (im_clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .read_data    (read_data),
    .alu_result   (alu_result),
    .write_reg    (write_reg),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .flush        (flush),
    .wb_stall     (wb_stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_count (retire_count)
  );

  task automatic tick();
    @(posedge im_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] rd, input logic [63:0] alu, input logic [4:0] wr,
                       input logic m2r, input logic rw);
    in_valid   = 1'b1;
    read_data  = rd;
    alu_result = alu;
    write_reg  = wr;
    mem_to_reg = m2r;
    reg_write  = rw;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; read_data = '0; alu_result = '0; write_reg = '0;
    mem_to_reg = 1'b0; reg_write = 1'b0; flush = 1'b0; wb_stall = 1'b0;
    tick();
    tick();
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_rf_we_low", rf_we, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_rf_we", rf_we, 0);
    chk("post_rst_waddr", rf_waddr, 0);
    chk("post_rst_wdata", rf_wdata, 0);
    chk("post_rst_count", retire_count, 0);

    // Load path
    drive(64'h1234, 64'h40, 5'd5, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("load_we", rf_we, 1);
    chk("load_waddr", rf_waddr, 5);
    chk("load_wdata", rf_wdata, 64'h1234);
    chk("load_count_before", retire_count, 0);
    tick();
    chk("load_count_after", retire_count, 1);
    chk("load_empty_we", rf_we, 0);

    // XZR destination retires without writing
    drive(64'h0, 64'h7, 5'd31, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("xzr_we", rf_we, 0);
    chk("xzr_wdata", rf_wdata, 64'h7);
    tick();
    chk("xzr_count", retire_count, 2);

    // Backpressure: A, B fill the buffer, C is held upstream
    wb_stall = 1'b1;
    drive(64'h0, 64'hA1, 5'd1, 1'b0, 1'b1);
    tick();
    drive(64'hB2, 64'h99, 5'd2, 1'b1, 1'b1);
    tick();
    drive(64'h0, 64'hC3, 5'd3, 1'b0, 1'b1);
    #1;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_stall_we", rf_we, 0);
    tick();
    chk("bp_held_ready", in_ready, 0);
    chk("bp_held_count", retire_count, 2);
    wb_stall = 1'b0;
    #1;
    chk("bp_a_we", rf_we, 1);
    chk("bp_a_waddr", rf_waddr, 1);
    chk("bp_a_wdata", rf_wdata, 64'hA1);
    tick();
    chk("bp_b_we", rf_we, 1);
    chk("bp_b_waddr", rf_waddr, 2);
    chk("bp_b_wdata", rf_wdata, 64'hB2);
    chk("bp_c_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_c_we", rf_we, 1);
    chk("bp_c_waddr", rf_waddr, 3);
    chk("bp_c_wdata", rf_wdata, 64'hC3);
    tick();
    chk("bp_count", retire_count, 5);
    chk("bp_empty_we", rf_we, 0);

    // Flush in state TWO with incoming valid
    wb_stall = 1'b1;
    drive(64'h0, 64'hD4, 5'd4, 1'b0, 1'b1);
    tick();
    drive(64'h0, 64'hE5, 5'd8, 1'b0, 1'b1);
    tick();
    drive(64'h0, 64'hF6, 5'd9, 1'b0, 1'b1);
    wb_stall = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_we", rf_we, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_ready", in_ready, 1);
    chk("flush_we_after", rf_we, 0);
    chk("flush_count", retire_count, 5);
    tick();
    chk("flush_no_commit_we", rf_we, 0);
    chk("flush_no_commit_count", retire_count, 5);

    // Mid-operation reset in state ONE under stall
    wb_stall = 1'b1;
    drive(64'h0, 64'h66, 5'd6, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", rf_we, 0);
    chk("midrst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    wb_stall = 1'b0;
    #1;
    chk("midrst_count", retire_count, 0);
    chk("midrst_we_after", rf_we, 0);
    chk("midrst_wdata", rf_wdata, 0);
    chk("midrst_ready_after", in_ready, 1);
    tick();
    chk("midrst_no_commit", retire_count, 0);

    // Full throughput stream up to the counter wrap
    for (int i = 0; i < 65536; i++) begin
      drive(64'h0, 64'(i), 5'd7, 1'b0, 1'b1);
      tick();
      if (i % 16384 == 100) begin
        chk("stream_wdata", rf_wdata, 64'(i));
        chk("stream_ready", in_ready, 1);
      end
    end
    chk("wrap_pre_count", retire_count, 16'hFFFF);
    in_valid = 1'b0;
    #1;
    chk("wrap_last_we", rf_we, 1);
    tick();
    chk("wrap_count", retire_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, meaning register-number width.
REQ-002 Data width SHALL be `WORD from definitions.vh, 64 bits.
REQ-003 Port im_clk  in  1: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst_n  in  1: synchronous, active-low reset, sampled on the rising edge of im_clk.
REQ-005 Port in_valid  in  1: the memory stage presents a completed instruction.
REQ-006 Port in_ready  out  1: this block can accept an entry this cycle.
REQ-007 Port read_data  in  `WORD: load data from the data memory.
REQ-008 Port alu_result  in  `WORD: ALU result forwarded through the memory stage.
REQ-009 Port write_reg  in  REG_ADDR_W: destination register number.
REQ-010 Port mem_to_reg  in  1: write-data select, where 1 selects read_data and 0 selects alu_result.
REQ-011 Port reg_write  in  1: the instruction writes the register file.
REQ-012 Port flush  in  1: discard all buffered and incoming entries.
REQ-013 Port wb_stall  in  1: the register file cannot commit this cycle.
REQ-014 Port rf_we  out  1: register-file write enable.
REQ-015 Port rf_waddr  out  REG_ADDR_W: register-file write address.
REQ-016 Port rf_wdata  out  `WORD: register-file write data.
REQ-017 Port retire_count  out  16: count of instructions retired.

Function
REQ-018 The block SHALL be a 2-entry in-order skid buffer.
- Each entry holds {wdata, waddr, reg_write}.
- wdata SHALL be captured at accept time as the mem_to_reg mux result (read_data or alu_result).
REQ-019 The state machine SHALL have states EMPTY, ONE and TWO, encoding the number of occupied entries.
REQ-020 in_ready SHALL be 1 when the state is not TWO and rst_n=1, and 0 otherwise.
REQ-021 An accept SHALL occur when in_valid=1 and in_ready=1 and flush=0.
- in_valid with in_ready=0 SHALL be ignored; the upstream stage holds the entry.
REQ-022 A retire SHALL occur when the state is not EMPTY and wb_stall=0 and flush=0.
- A retire dequeues the head entry.
REQ-023 The rf_* outputs SHALL be combinational from the head entry:
- rf_we = head.reg_write AND retire AND (head.waddr != 31).
- rf_waddr = head.waddr.
- rf_wdata = head.wdata.
REQ-024 Destination register 31 (XZR) SHALL still retire and count, but with rf_we=0.
REQ-025 State transitions SHALL follow the occupancy change:
- Accept only: +1 entry.
- Retire only: -1 entry.
- Accept and retire in the same cycle: occupancy unchanged, FIFO order preserved.
- In state ONE, a simultaneous accept and retire SHALL place the new entry at the head in the next cycle.
REQ-026 Latency SHALL be 1 cycle: an entry accepted in cycle N with wb_stall=0 SHALL drive rf_* in cycle N+1.
REQ-027 Full throughput SHALL be supported: one accept and one retire per cycle indefinitely while wb_stall=0.
REQ-028 flush=1 SHALL take priority over everything else:
- rf_we=0 that cycle.
- No accept and no retire that cycle.
- State goes to EMPTY at the next edge.
- retire_count is unchanged.
REQ-029 retire_count SHALL increment by 1 on every retire and wrap from 0xFFFF to 0x0000.
REQ-030 wb_stall=1 SHALL freeze the head entry and rf_we=0.
- Accepts continue until the state is TWO.

Reset
REQ-031 While rst_n=0 at a rising edge, the following SHALL hold at that edge:
- State goes to EMPTY.
- retire_count goes to 0.
- Entry contents go to 0.
REQ-032 Outputs after reset SHALL be rf_we=0, rf_waddr=0, rf_wdata=0 and in_ready=1 (with rst_n=1).
REQ-033 While rst_n=0, in_ready SHALL be 0, no accept or retire SHALL occur, and rf_we SHALL be 0.
REQ-034 A reset mid-operation SHALL discard all entries and SHALL NOT commit them.

Verification
REQ-035 Load path: accept {read_data=0x1234, alu_result=0x40, write_reg=5, mem_to_reg=1, reg_write=1} -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, and retire_count=1 after the following edge.
REQ-036 Backpressure: with wb_stall=1, accept A and B -> in_ready=0 and a third entry C is held. Then release wb_stall -> A, B and C commit on three consecutive cycles, in order.
REQ-037 XZR: accept alu_result=7, write_reg=31, reg_write=1 -> rf_we stays 0 and retire_count increments by 1.
REQ-038 Flush: in state TWO, assert flush together with in_valid -> rf_we=0 and the next state is EMPTY with in_ready=1. Nothing from either buffered entry is ever committed.
REQ-039 Counter wrap: preload 0xFFFF retires, then one more retire -> retire_count=0x0000.
REQ-040 Mid-operation reset: in state ONE with wb_stall=1, drive rst_n=0 for one edge -> rf_we=0, retire_count=0, and the state is EMPTY.
